// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory path: bus widths and the
// encoding of which requester currently owns the data_ram port.
package mips_mem_pkg;

   localparam int DMEM_AW = 32;
   localparam int DMEM_DW = 32;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DBG  = 2'd2
   } owner_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at SAT_MAX instead of wrapping; clr wins over inc.
module sat_counter #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] SAT_MAX = '1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clock) begin
      if (reset || clr) begin
         count <= '0;
      end else if (inc && (count != SAT_MAX)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data_ram port between the MEM stage and a debug/loader
// port. The CPU wins by default; a starved debug request is force-granted.
module dmem_arbiter
   import mips_mem_pkg::*;
#(
   parameter int MAX_CPU_RUN = 8,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   cpu_req,
   input  logic                   cpu_wen,
   input  logic [DMEM_AW-1:0]     cpu_addr,
   input  logic [DMEM_DW-1:0]     cpu_wdata,
   output logic [DMEM_DW-1:0]     cpu_rdata,
   output logic                   cpu_stall,
   input  logic                   dbg_valid,
   output logic                   dbg_ready,
   input  logic                   dbg_wen,
   input  logic [DMEM_AW-1:0]     dbg_addr,
   input  logic [DMEM_DW-1:0]     dbg_wdata,
   output logic                   dbg_rvalid,
   output logic [DMEM_DW-1:0]     dbg_rdata,
   output logic [DMEM_AW-1:0]     ram_raddr,
   output logic [DMEM_AW-1:0]     ram_waddr,
   output logic                   ram_wen,
   output logic [DMEM_DW-1:0]     ram_win,
   input  logic [DMEM_DW-1:0]     ram_rout,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   localparam int                  STARVE_W   = $clog2(MAX_CPU_RUN + 1);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_CPU_RUN);

   logic                starveCnt_unused;
   logic [STARVE_W-1:0] starveCnt;
   logic                dbgGnt;
   logic                cpuGnt;
   owner_t              owner;
   logic [DMEM_AW-1:0]  ramAddr;
   logic                vldP1;
   logic [DMEM_DW-1:0]  rdataP1;

   assign starveCnt_unused = 1'b0;

   assign dbgGnt    = dbg_valid && (!cpu_req || (starveCnt == STARVE_MAX));
   assign cpuGnt    = cpu_req && !dbgGnt;
   assign dbg_ready = dbgGnt;
   assign cpu_stall = cpu_req && dbgGnt;
   assign cpu_rdata = ram_rout;

   // Counts cycles a pending debug request loses to the CPU.
   sat_counter #(
      .WIDTH   (STARVE_W),
      .SAT_MAX (STARVE_MAX)
   ) starveCounter (
      .clock (clock),
      .reset (reset),
      .inc   (dbg_valid && cpu_req),
      .clr   (dbgGnt || !dbg_valid),
      .count (starveCnt)
   );

   sat_counter #(
      .WIDTH (STALL_CNT_W)
   ) stallCounter (
      .clock (clock),
      .reset (reset),
      .inc   (cpu_stall),
      .clr   (1'b0),
      .count (stall_cnt)
   );

   always_comb begin
      owner = OWN_NONE;
      if (dbgGnt) begin
         owner = OWN_DBG;
      end else if (cpuGnt) begin
         owner = OWN_CPU;
      end
   end

   always_comb begin
      ramAddr = '0;
      ram_win = '0;
      unique case (owner)
         OWN_DBG: begin
            ramAddr = dbg_addr;
            ram_win = dbg_wdata;
         end
         OWN_CPU: begin
            ramAddr = cpu_addr;
            ram_win = cpu_wdata;
         end
         default: begin
            ramAddr = '0;
            ram_win = '0;
         end
      endcase
   end

   assign ram_raddr = ramAddr;
   assign ram_waddr = ramAddr;
   assign ram_wen   = !reset && ((dbgGnt && dbg_wen) || (cpuGnt && cpu_wen));

   // Debug read response stage: data captured from the handshake cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         vldP1   <= 1'b0;
         rdataP1 <= '0;
      end else begin
         vldP1 <= dbgGnt && !dbg_wen;
         if (dbgGnt && !dbg_wen) begin
            rdataP1 <= ram_rout;
         end
      end
   end

   // Masking with reset drops a response that is due in a reset cycle.
   assign dbg_rvalid = vldP1 && !reset;
   assign dbg_rdata  = rdataP1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Vector/scoreboard bench for dmem_arbiter with a behavioural data_ram
// attached to the ram_* port.
module tb_dmem_arbiter;

   localparam int MAX_RUN = 8;
   localparam int SW      = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          cpu_req = 1'b0, cpu_wen = 1'b0;
   logic [31:0]   cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
   logic          cpu_stall;
   logic          dbg_valid = 1'b0, dbg_ready, dbg_wen = 1'b0;
   logic [31:0]   dbg_addr = '0, dbg_wdata = '0;
   logic          dbg_rvalid;
   logic [31:0]   dbg_rdata;
   logic [31:0]   ram_raddr, ram_waddr, ram_win, ram_rout;
   logic          ram_wen;
   logic [SW-1:0] stall_cnt;

   always #5 clock = ~clock;

   dmem_arbiter #(.MAX_CPU_RUN(MAX_RUN), .STALL_CNT_W(SW)) dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_wen(dbg_wen),
      .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rvalid(dbg_rvalid),
      .dbg_rdata(dbg_rdata), .ram_raddr(ram_raddr), .ram_waddr(ram_waddr),
      .ram_wen(ram_wen), .ram_win(ram_win), .ram_rout(ram_rout),
      .stall_cnt(stall_cnt)
   );

   // Behavioural data_ram: combinational read, write at the clock edge.
   logic [31:0] mem [0:255];
   assign ram_rout = mem[ram_raddr[9:2]];
   always @(posedge clock) if (ram_wen) mem[ram_waddr[9:2]] <= ram_win;

   typedef struct {
      logic        rst;
      logic        cReq, cWen;
      logic [31:0] cAddr, cWd;
      logic        dVal, dWen;
      logic [31:0] dAddr, dWd;
      logic        eStall, eReady, eWen;
   } vec_t;

   int          nCmp = 0;
   int          nErr = 0;
   logic [31:0] refMem [0:255];
   logic [31:0] rdQ [$];
   logic        expRv = 1'b0;
   logic [31:0] lastRd = '0;
   int          expStallCnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rst, input logic cReq, input logic cWen,
                               input logic [31:0] cAddr, input logic [31:0] cWd,
                               input logic dVal, input logic dWen,
                               input logic [31:0] dAddr, input logic [31:0] dWd,
                               input logic eStall, input logic eReady, input logic eWen);
      vec_t v;
      v.rst = rst; v.cReq = cReq; v.cWen = cWen; v.cAddr = cAddr; v.cWd = cWd;
      v.dVal = dVal; v.dWen = dWen; v.dAddr = dAddr; v.dWd = dWd;
      v.eStall = eStall; v.eReady = eReady; v.eWen = eWen;
      return v;
   endfunction

   // Called at posedge+1: drive, check mid-cycle, then advance the model.
   task automatic runVec(input vec_t v, input string tag);
      logic [31:0] popped;
      reset = v.rst;
      cpu_req = v.cReq; cpu_wen = v.cWen; cpu_addr = v.cAddr; cpu_wdata = v.cWd;
      dbg_valid = v.dVal; dbg_wen = v.dWen; dbg_addr = v.dAddr; dbg_wdata = v.dWd;
      #3;
      if (expRv && !v.rst) begin
         chk({tag, " rvalid"}, 32'(dbg_rvalid), 32'd1);
         popped = rdQ.pop_front();
         chk({tag, " dbg_rdata"}, dbg_rdata, popped);
         lastRd = popped;
      end else begin
         chk({tag, " rvalid"}, 32'(dbg_rvalid), 32'd0);
         if (expRv) popped = rdQ.pop_front();
         else if (!v.rst) chk({tag, " rdata hold"}, dbg_rdata, lastRd);
      end
      chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'(expStallCnt));
      chk({tag, " cpu_stall"}, 32'(cpu_stall), 32'(v.eStall));
      chk({tag, " dbg_ready"}, 32'(dbg_ready), 32'(v.eReady));
      chk({tag, " ram_wen"},   32'(ram_wen),   32'(v.eWen));
      if (v.cReq && !v.cWen && !v.eStall && !v.rst)
         chk({tag, " cpu_rdata"}, cpu_rdata, refMem[v.cAddr[9:2]]);
      if (v.rst) begin
         expStallCnt = 0; expRv = 1'b0; lastRd = '0; rdQ.delete();
      end else begin
         if (v.eStall && expStallCnt < (1 << SW) - 1) expStallCnt++;
         expRv = v.eReady && !v.dWen;
         if (expRv) rdQ.push_back(refMem[v.dAddr[9:2]]);
         if (v.eWen) begin
            if (v.eReady) refMem[v.dAddr[9:2]] = v.dWd;
            else          refMem[v.cAddr[9:2]] = v.cWd;
         end
      end
      @(posedge clock); #1;
   endtask

   vec_t basic [$];
   vec_t idle;
   logic f;

   initial begin
      for (int i = 0; i < 256; i++) begin mem[i] = '0; refMem[i] = '0; end
      idle = mk(0, 0,0,0,0, 0,0,0,0, 0,0,0);

      basic.push_back(idle);
      basic.push_back(mk(0, 1,1,32'h10,32'hDEADBEEF, 0,0,0,0,           0,0,1));
      basic.push_back(mk(0, 1,0,32'h10,0,            0,0,0,0,           0,0,0));
      basic.push_back(mk(0, 0,0,0,0,                 1,0,32'h10,0,      0,1,0));
      basic.push_back(idle);
      basic.push_back(idle);
      basic.push_back(mk(0, 0,0,0,0,                 1,1,32'h30,32'hA5A5, 0,1,1));
      basic.push_back(mk(0, 0,0,0,0,                 1,0,32'h30,0,      0,1,0));
      basic.push_back(mk(0, 1,0,32'h30,0,            0,0,0,0,           0,0,0));
      basic.push_back(idle);

      repeat (2) @(posedge clock);
      #1;
      for (int i = 0; i < basic.size(); i++) runVec(basic[i], $sformatf("basic%0d", i));

      // Starvation under full CPU load: forced grants in cycles 8 and 17.
      for (int k = 0; k < 18; k++) begin
         f = (k == 8) || (k == 17);
         runVec(mk(0, 1,0,32'h40,0, 1,0,32'h10,0, f,f,0), $sformatf("starve%0d", k));
      end
      runVec(idle, "starve_end");
      #3 chk("stall_cnt after starvation", 32'(stall_cnt), 32'd2);
      #0;
      @(posedge clock); #1;

      // Same-address writes: debug wins the forced cycle, held CPU write follows.
      for (int k = 0; k < 8; k++)
         runVec(mk(0, 1,0,32'h40,0, 1,1,32'h20,32'h1111, 0,0,0), $sformatf("same%0d", k));
      runVec(mk(0, 1,1,32'h20,32'h2222, 1,1,32'h20,32'h1111, 1,1,1), "same_forced");
      runVec(mk(0, 1,1,32'h20,32'h2222, 0,0,0,0,             0,0,1), "same_cpu");
      runVec(mk(0, 0,0,0,0,             1,0,32'h20,0,        0,1,0), "same_rd");
      runVec(idle, "same_rsp");
      chk("readback 0x20", mem[8], 32'h2222);

      // Saturation of the 4-bit stall counter.
      for (int j = 0; j < 180; j++) begin
         f = (j % 9) == 8;
         runVec(mk(0, 1,0,32'h40,0, 1,0,32'h10,0, f,f,0), $sformatf("sat%0d", j));
      end
      runVec(idle, "sat_end");
      #3 chk("stall_cnt saturated", 32'(stall_cnt), 32'd15);
      @(posedge clock); #1;

      // Reset while a debug request has been partially starved.
      for (int k = 0; k < 4; k++)
         runVec(mk(0, 1,0,32'h40,0, 1,0,32'h10,0, 0,0,0), $sformatf("prerst%0d", k));
      runVec(mk(1, 1,1,32'h30,32'h5555, 1,0,32'h10,0, 0,0,0), "rst1");
      for (int k = 0; k < 9; k++) begin
         f = (k == 8);
         runVec(mk(0, 1,0,32'h40,0, 1,0,32'h10,0, f,f,0), $sformatf("postrst%0d", k));
      end

      // Reset in the cycle after a debug read handshake.
      runVec(idle, "rst2_idle");
      runVec(mk(0, 0,0,0,0, 1,0,32'h20,0, 0,1,0), "rst2_hs");
      runVec(mk(1, 1,1,32'h30,32'h5555, 0,0,0,0, 0,0,0), "rst2");
      runVec(idle, "rst2_after");
      runVec(mk(0, 1,0,32'h30,0, 0,0,0,0, 0,0,0), "rst2_rd30");
      runVec(idle, "final");
      chk("scoreboard drained", 32'(rdQ.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
